// File: rtl/axis_xor_pkg.sv
// Shared types and the XOR reduction used by the axis_xor stream blocks.
// The reduction runs on a fixed maximum width; callers cast to their own WIDTH.
package axis_xor_pkg;

    localparam int unsigned MAX_W    = 1024;
    localparam int unsigned MAX_HALF = MAX_W / 2;

    typedef enum logic [1:0] {
        XOR_PAIR,
        XOR_FOLD,
        XOR_KEY,
        XOR_RSVD
    } xor_mode_e;

    typedef enum logic {
        IDLE,
        IN_PKT
    } pkt_state_e;

    // half is the caller's output width (WIDTH/2); bits above it stay zero.
    // The reserved mode folds, exactly like XOR_FOLD.
    function automatic logic [MAX_HALF-1:0] xor_reduce(
        input logic [MAX_W-1:0]    data,
        input xor_mode_e           mode,
        input logic [MAX_HALF-1:0] key,
        input int unsigned         half
    );
        logic [MAX_HALF-1:0] res;
        res = '0;
        for (int unsigned i = 0; i < MAX_HALF; i++) begin
            if (i < half) begin
                case (mode)
                    XOR_PAIR: res[i] = data[2*i] ^ data[2*i+1];
                    XOR_KEY:  res[i] = data[i] ^ key[i];
                    default:  res[i] = data[i] ^ data[i+half];
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry AXIS register slice: registered output stage plus one skid entry.
// in_ready is registered and only drops once the skid entry is occupied.
module axis_skid_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;

    logic [DATA_W-1:0] out_data_d;
    logic              out_valid_d;
    logic [DATA_W-1:0] skid_data_d;
    logic              skid_valid_d;
    logic              in_fire;

    // Output stage refills from skid first; new beats only land in skid while the output stalls.
    always_comb begin
        out_data_d   = out_data;
        out_valid_d  = out_valid;
        skid_data_d  = skid_data;
        skid_valid_d = skid_valid;
        in_fire      = in_valid && in_ready;

        if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_data_d   = skid_data;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_fire) begin
            skid_data_d  = in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b0;
        end else begin
            out_data   <= out_data_d;
            out_valid  <= out_valid_d;
            skid_data  <= skid_data_d;
            skid_valid <= skid_valid_d;
            in_ready   <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/axis_xor_v2.sv
// AXI-Stream XOR reducer: WIDTH-bit beats in, WIDTH/2-bit beats out, mode fixed per packet.
// Buffered by axis_skid_reg for full throughput; exposes beat/packet counters and a sticky mode error.
module axis_xor_v2 #(
    parameter int unsigned WIDTH = 512,
    parameter int unsigned CNT_W = 16
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [1:0]         mode,
    input  logic [WIDTH/2-1:0] key,
    input  logic [WIDTH-1:0]   slave_tdata,
    input  logic               slave_tvalid,
    output logic               slave_tready,
    input  logic               slave_tlast,
    output logic [WIDTH/2-1:0] master_tdata,
    output logic               master_tvalid,
    input  logic               master_tready,
    output logic               master_tlast,
    output logic [CNT_W-1:0]   beat_count,
    output logic [CNT_W-1:0]   pkt_count,
    output logic               mode_err
);
    import axis_xor_pkg::*;

    localparam int unsigned OUT_W = WIDTH / 2;

    if (WIDTH < 2 || (WIDTH % 2) != 0 || WIDTH > MAX_W) begin : g_bad_width
        $error("axis_xor_v2: WIDTH must be even, at least 2 and at most MAX_W");
    end

    pkt_state_e       state_q;
    pkt_state_e       state_d;
    xor_mode_e        mode_l;
    logic [OUT_W-1:0] key_l;
    xor_mode_e        mode_c;
    logic [OUT_W-1:0] key_c;
    logic [OUT_W-1:0] result_c;
    logic [OUT_W:0]   out_payload;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = slave_tvalid && slave_tready;
    assign out_fire = master_tvalid && master_tready;

    // First beat of a packet uses the live mode/key; later beats use the latched copies.
    always_comb begin
        state_d = state_q;
        mode_c  = mode_l;
        key_c   = key_l;
        if (state_q == IDLE) begin
            mode_c = xor_mode_e'(mode);
            key_c  = key;
        end
        if (in_fire) begin
            state_d = slave_tlast ? IDLE : IN_PKT;
        end
    end

    assign result_c = OUT_W'(xor_reduce(MAX_W'(slave_tdata), mode_c, MAX_HALF'(key_c), OUT_W));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            mode_l   <= XOR_PAIR;
            key_l    <= '0;
            mode_err <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire && state_q == IDLE) begin
                mode_l <= mode_c;
                key_l  <= key_c;
                if (mode_c == XOR_RSVD) begin
                    mode_err <= 1'b1;
                end
            end
        end
    end

    // Counters follow the output handshake, so they only see beats actually delivered.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            beat_count <= '0;
            pkt_count  <= '0;
        end else if (out_fire) begin
            if (master_tlast) begin
                beat_count <= '0;
                pkt_count  <= pkt_count + CNT_W'(1);
            end else begin
                beat_count <= beat_count + CNT_W'(1);
            end
        end
    end

    axis_skid_reg #(
        .DATA_W (OUT_W + 1)
    ) u_skid (
        .clk       (aclk),
        .rst_n     (aresetn),
        .in_data   ({result_c, slave_tlast}),
        .in_valid  (slave_tvalid),
        .in_ready  (slave_tready),
        .out_data  (out_payload),
        .out_valid (master_tvalid),
        .out_ready (master_tready)
    );

    assign master_tdata = out_payload[OUT_W:1];
    assign master_tlast = out_payload[0];

endmodule

// File: tb/tb_axis_xor_v2.sv
// Self-checking bench for axis_xor_v2 (WIDTH=8, CNT_W=4): directed scenarios plus
// randomized traffic against a queue-based reference model sampled on the falling edge.
module tb_axis_xor_v2;

    localparam int unsigned W  = 8;
    localparam int unsigned OW = 4;
    localparam int unsigned CW = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [1:0]    mode;
    logic [OW-1:0] key;
    logic [W-1:0]  slave_tdata;
    logic          slave_tvalid;
    logic          slave_tready;
    logic          slave_tlast;
    logic [OW-1:0] master_tdata;
    logic          master_tvalid;
    logic          master_tready;
    logic          master_tlast;
    logic [CW-1:0] beat_count;
    logic [CW-1:0] pkt_count;
    logic          mode_err;

    always #5 aclk = ~aclk;

    axis_xor_v2 #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .mode          (mode),
        .key           (key),
        .slave_tdata   (slave_tdata),
        .slave_tvalid  (slave_tvalid),
        .slave_tready  (slave_tready),
        .slave_tlast   (slave_tlast),
        .master_tdata  (master_tdata),
        .master_tvalid (master_tvalid),
        .master_tready (master_tready),
        .master_tlast  (master_tlast),
        .beat_count    (beat_count),
        .pkt_count     (pkt_count),
        .mode_err      (mode_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference XOR written straight from the mode definitions.
    function automatic logic [3:0] ref_xor(input logic [7:0] d, input int m, input logic [3:0] k);
        logic [3:0] r;
        case (m)
            0: for (int i = 0; i < 4; i++) r[i] = d[2*i] ^ d[2*i+1];
            2: r = d[3:0] ^ k;
            default: r = d[3:0] ^ d[7:4];
        endcase
        return r;
    endfunction

    typedef struct packed {
        logic [3:0] d;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    bit         m_inpkt;
    bit         m_err;
    bit         stall;
    int         m_lmode;
    logic [3:0] m_lkey;
    int         m_beats;
    int         m_pkts;
    logic [3:0] hold_d;
    logic       hold_l;

    // Reference model: predicts each output beat at input acceptance, checks it at output acceptance.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            m_inpkt = 1'b0;
            m_err   = 1'b0;
            stall   = 1'b0;
            m_beats = 0;
            m_pkts  = 0;
        end else begin
            check("beat_count", 32'(beat_count), 32'(m_beats));
            check("pkt_count", 32'(pkt_count), 32'(m_pkts));
            check("mode_err", 32'(mode_err), 32'(m_err));
            if (stall) begin
                check("hold_valid", 32'(master_tvalid), 32'(1));
                check("hold_data", 32'(master_tdata), 32'(hold_d));
                check("hold_last", 32'(master_tlast), 32'(hold_l));
            end
            if (master_tvalid && master_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(1), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(master_tdata), 32'(e.d));
                    check("out_last", 32'(master_tlast), 32'(e.l));
                    if (e.l) begin
                        m_beats = 0;
                        m_pkts  = (m_pkts + 1) % 16;
                    end else begin
                        m_beats = (m_beats + 1) % 16;
                    end
                end
            end
            stall  = master_tvalid && !master_tready;
            hold_d = master_tdata;
            hold_l = master_tlast;
            if (slave_tvalid && slave_tready) begin
                if (!m_inpkt) begin
                    m_lmode = int'(mode);
                    m_lkey  = key;
                    if (mode == 2'd3) m_err = 1'b1;
                end
                exp_q.push_back('{d: ref_xor(slave_tdata, m_lmode, m_lkey), l: slave_tlast});
                m_inpkt = !slave_tlast;
            end
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Present one beat and hold it until accepted; tvalid is left high for back-to-back use.
    task automatic send(input logic [7:0] d, input logic l, input logic [1:0] m, input logic [3:0] k);
        bit done;
        done         = 1'b0;
        slave_tdata  = d;
        slave_tlast  = l;
        mode         = m;
        key          = k;
        slave_tvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge aclk);
            done = slave_tready;
            tick();
        end
        if (!done) check("send_timeout", 32'(0), 32'(1));
    endtask

    task automatic idle();
        slave_tvalid = 1'b0;
        slave_tlast  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int sent;
        int budget;

        aresetn       = 1'b0;
        mode          = 2'd0;
        key           = '0;
        slave_tdata   = '0;
        slave_tvalid  = 1'b0;
        slave_tlast   = 1'b0;
        master_tready = 1'b1;

        // Reset state, then tready rises on the first edge after release.
        #12;
        check("rst_tvalid", 32'(master_tvalid), 32'(0));
        check("rst_tdata", 32'(master_tdata), 32'(0));
        check("rst_tlast", 32'(master_tlast), 32'(0));
        check("rst_tready", 32'(slave_tready), 32'(0));
        check("rst_pkt", 32'(pkt_count), 32'(0));
        check("rst_err", 32'(mode_err), 32'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        tick();
        check("tready_after_rst", 32'(slave_tready), 32'(1));

        // Mode 0 single beat, one cycle latency.
        send(8'hA6, 1'b1, 2'd0, 4'h0);
        idle();
        @(negedge aclk);
        check("m0_valid", 32'(master_tvalid), 32'(1));
        check("m0_data", 32'(master_tdata), 32'(4'hF));
        check("m0_last", 32'(master_tlast), 32'(1));
        tick();
        @(negedge aclk);
        check("m0_pkt", 32'(pkt_count), 32'(1));
        tick();

        // Modes 1 and 2.
        send(8'hA6, 1'b1, 2'd1, 4'h0);
        idle();
        @(negedge aclk);
        check("m1_data", 32'(master_tdata), 32'(4'hC));
        tick();
        send(8'hA6, 1'b1, 2'd2, 4'h5);
        idle();
        @(negedge aclk);
        check("m2_data", 32'(master_tdata), 32'(4'h3));
        tick();

        // Mode latched per packet; back-to-back next packet picks up the new mode.
        send(8'h3C, 1'b0, 2'd0, 4'h0);
        send(8'h5A, 1'b0, 2'd1, 4'h9);
        send(8'hF0, 1'b1, 2'd1, 4'h9);
        send(8'hA6, 1'b1, 2'd1, 4'h0);
        idle();
        @(negedge aclk);
        check("latch_next_pkt", 32'(master_tdata), 32'(4'hC));
        repeat (3) tick();

        // Backpressure: two beats absorbed, then tready falls.
        master_tready = 1'b0;
        mode          = 2'd2;
        key           = 4'(($urandom));
        slave_tvalid  = 1'b1;
        acc           = 0;
        sent          = 0;
        for (int c = 0; c < 4; c++) begin
            slave_tdata = 8'h10 + 8'(sent);
            slave_tlast = 1'b0;
            @(negedge aclk);
            if (slave_tready) begin
                acc++;
                sent++;
            end
            tick();
        end
        check("bp_accepted", 32'(acc), 32'(2));
        check("bp_tready_low", 32'(slave_tready), 32'(0));
        master_tready = 1'b1;
        budget        = 30;
        while (sent < 6 && budget > 0) begin
            slave_tdata = 8'h10 + 8'(sent);
            slave_tlast = (sent == 5);
            @(negedge aclk);
            if (slave_tready) sent++;
            tick();
            budget--;
        end
        check("bp_all_sent", 32'(sent), 32'(6));
        idle();
        repeat (4) tick();

        // Reserved mode: folds and sets a sticky error.
        send(8'h3C, 1'b0, 2'd3, 4'h0);
        send(8'h81, 1'b1, 2'd0, 4'h0);
        idle();
        tick();
        check("err_set", 32'(mode_err), 32'(1));
        send(8'hA6, 1'b1, 2'd0, 4'h0);
        idle();
        repeat (2) tick();
        check("err_sticky", 32'(mode_err), 32'(1));

        // Reset mid-packet with the skid full clears outputs asynchronously.
        master_tready = 1'b0;
        send(8'h11, 1'b0, 2'd0, 4'h0);
        send(8'h22, 1'b0, 2'd0, 4'h0);
        slave_tdata = 8'h33;
        #3;
        aresetn = 1'b0;
        #1;
        check("arst_tvalid", 32'(master_tvalid), 32'(0));
        check("arst_tdata", 32'(master_tdata), 32'(0));
        check("arst_tready", 32'(slave_tready), 32'(0));
        check("arst_pkt", 32'(pkt_count), 32'(0));
        check("arst_err", 32'(mode_err), 32'(0));
        idle();
        master_tready = 1'b1;
        @(negedge aclk);
        tick();
        aresetn = 1'b1;
        tick();
        send(8'hA6, 1'b1, 2'd0, 4'h0);
        idle();
        tick();
        @(negedge aclk);
        check("post_rst_pkt", 32'(pkt_count), 32'(1));
        check("post_rst_beat", 32'(beat_count), 32'(0));
        tick();

        // Randomized traffic; CNT_W=4 makes both counters wrap.
        for (int i = 0; i < 600; i++) begin
            slave_tvalid  = ($urandom % 4) != 0;
            slave_tdata   = 8'($urandom);
            slave_tlast   = ($urandom % 3) == 0;
            mode          = 2'($urandom);
            key           = 4'($urandom);
            master_tready = ($urandom % 3) != 0;
            tick();
        end
        idle();
        master_tready = 1'b1;
        repeat (5) tick();
        check("drain_empty", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
